uart_char_rx: RTL and testbench
===============================

# uart_char_rx

Serial-to-byte front end for the word-checking pipeline. It receives 8N1 asynchronous serial data on `rxd`, recovers each character by mid-bit sampling, and maps whitespace control codes to ASCII space. It emits one `char_out`/`char_valid` pulse per good frame, and the downstream keyword checker consumes that byte stream. Frames with a bad stop bit are dropped and flagged on `frame_err`.

## Interface
- `CLKS_PER_BIT`, 16, clk cycles per serial bit; even, ≥ 4
- `clk` in 1, system clock, rising edge
- `reset` in 1, reset, asynchronous, active-high; clock `clk`
- `rxd` in 1, asynchronous serial line, idle high
- `char_out` out 8, last accepted character after whitespace mapping; held between frames
- `char_valid` out 1, one-cycle pulse when `char_out` is updated
- `frame_err` out 1, one-cycle pulse when a frame is rejected for a low stop bit
- `busy` out 1, high whenever the FSM is not in IDLE

## Operation
- **Synchronizer:** `rxd` passes through two flops, both reset to 1. The FSM only sees the synchronized value `rxs`.
- **Counters:**
  - bit-timer `cnt`, width `$clog2(CLKS_PER_BIT)`
  - bit index `idx`, 3 bits
  - shift register `sh`, 8 bits
- **IDLE:**
  - If `rxs==0`: clear `cnt`, go to START.
  - Otherwise stay in IDLE.
- **START:** `cnt` counts up. When `cnt==CLKS_PER_BIT/2-1` (mid start bit):
  - if `rxs==0`: clear `cnt` and `idx`, go to DATA
  - else the event was a glitch: go to IDLE with no output
- **DATA:** `cnt` counts to `CLKS_PER_BIT-1`, then:
  - shift `rxs` into the MSB of `sh` (LSB-first reception) and clear `cnt`
  - if `idx==7`, go to STOP; else increment `idx`
- **STOP:** at `cnt==CLKS_PER_BIT-1`:
  - if `rxs==1`: `char_out <= map(sh)`, pulse `char_valid`, go to IDLE
  - if `rxs==0`: pulse `frame_err`, leave `char_out` unchanged, go to BREAK
- **BREAK:** stay until `rxs==1`, then go to IDLE. A held-low line (break condition) therefore produces exactly one `frame_err` and no characters.
- **Whitespace map:** 0x09, 0x0A and 0x0D become 0x20. Every other byte, including 0x00 and values ≥ 0x80, passes through unchanged. Case is not altered.
- **Reset values:**
  - `char_out=0`, `char_valid=0`, `frame_err=0`, `busy=0`
  - state IDLE, `cnt=0`, `idx=0`, `sh=0`, sync flops = 1
- **Reset mid-frame:** the partial frame is discarded and nothing is emitted. After release, the first falling edge on `rxd` starts a new frame.
- `char_valid` and `frame_err` are never high in the same cycle.

## Timing
- **T0** is the first `clk` edge that samples `rxd==0` in the first sync flop.
  - START is entered at edge T0+2.
  - The mid-start check happens at edge T0+2+CLKS_PER_BIT/2.
  - Data bit i is sampled at T0+2+CLKS_PER_BIT/2+(i+1)·CLKS_PER_BIT.
  - The stop bit is sampled at T0+2+CLKS_PER_BIT/2+9·CLKS_PER_BIT.
  - With `CLKS_PER_BIT=16`, the stop sample is at T0+154.
- `char_valid`/`frame_err` are registered at the stop-sample edge and are high for exactly the following cycle.
- **Back-to-back frames:** the FSM is in IDLE the cycle after the stop sample. A start bit beginning at the nominal end of the stop bit is caught with no lost characters.
- **Throughput:** at most one character per 10·CLKS_PER_BIT cycles.
- `busy` rises at edge T0+2 and falls at the stop-sample edge, or on BREAK exit.

## Structure
- **Package `uart_pkg`:**
  - state enum {IDLE, START, DATA, STOP, BREAK}
  - ASCII constants `ASC_SPACE`=8'h20, `ASC_TAB`=8'h09, `ASC_LF`=8'h0A, `ASC_CR`=8'h0D
  - function `ws_map(byte)`
- **Sub-module `rx_sync`:** 2-flop synchronizer with a reset value parameter. Instantiated once with reset value 1.

## Test plan
All scenarios use `CLKS_PER_BIT=16` and an ideal bit period of 16 clk.
- **Single character:** send 'b' (0x62) → one `char_valid` pulse at T0+155 with `char_out=0x62`; `frame_err` stays 0.
- **Back-to-back stream:** send "Begin\tend" with no idle gap → 9 pulses with `char_out` = 42,65,67,69,6E,20,65,6E,64 (hex); tab is mapped to 0x20.
- **Start glitch:** `rxd` low for 4 cycles, then high → no pulse; `busy` returns to 0 by T0+11.
- **Framing error:** send 0x41 with stop bit 0, then line high → one `frame_err` pulse, no `char_valid`, `char_out` keeps its prior value. The next good 0x42 is received normally.
- **Break condition:** `rxd` held low for 400 cycles → exactly one `frame_err`; no characters; `busy` stays 1 until the line goes high.
- **Reset mid-frame:** assert `reset` during data bit 4 → all outputs 0 immediately. After release, 'e' (0x65) is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared types and helpers for the serial character receiver.
//   rx_state_e : receiver FSM states
//   ASC_*      : ASCII constants used by the whitespace map
//   ws_map()   : folds TAB / LF / CR onto SPACE, passes every other byte
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_e;

    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_TAB   = 8'h09;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_CR    = 8'h0D;

    // Only the three whitespace control codes are rewritten. NUL, high-bit
    // bytes and letters of either case pass through untouched.
    function automatic logic [7:0] ws_map(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if ((b == ASC_TAB) || (b == ASC_LF) || (b == ASC_CR)) begin
            r = ASC_SPACE;
        end
        return r;
    endfunction

endpackage

// File: rtl/rx_sync.sv
// rx_sync
// Two-flop synchronizer for a single asynchronous input.
//   clk       : destination clock
//   reset     : asynchronous, active-high; both flops load RESET_VAL
//   d_i       : asynchronous input
//   q_o       : synchronized output (two clk cycles of latency)
module rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_char_rx.sv
// uart_char_rx
// 8N1 serial receiver feeding the keyword checker. Recovers each character by
// mid-bit sampling, maps TAB/LF/CR to SPACE and emits one pulse per good frame.
// Frames whose stop bit is low are dropped and reported on frame_err; the
// receiver then waits for the line to return high before hunting again.
//
// Ports
//   clk          : system clock, rising edge
//   reset        : asynchronous, active-high
//   rxd          : asynchronous serial line, idle high
//   char_out     : last accepted character after mapping; held between frames
//   char_valid   : one-cycle pulse when char_out is updated
//   frame_err    : one-cycle pulse when a frame is rejected (low stop bit)
//   busy         : high whenever the FSM is not in IDLE
//   dbg_state_o  : current FSM state (rx_state_e encoding) for observation
//
// Handshake: char_valid / frame_err are single-cycle strobes with no ready;
// the consumer must take char_out in the cycle char_valid is high. The two
// strobes are mutually exclusive because they come from opposite branches
// of the same stop-bit decision.
module uart_char_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] char_out,
    output logic       char_valid,
    output logic       frame_err,
    output logic       busy,
    output logic [2:0] dbg_state_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic rxs;

    rx_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rxd),
        .q_o   (rxs)
    );

    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [2:0]    idx_q,   idx_d;
    logic [7:0]    sh_q,    sh_d;
    logic [7:0]    char_q,  char_d;
    logic          valid_q, valid_d;
    logic          err_q,   err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            char_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            char_q  <= char_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        char_d  = char_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rxs) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end

            // Re-check the line half a bit after the falling edge so a short
            // glitch does not start a frame. From here on every sample lands
            // in the middle of a bit cell.
            START: begin
                if (cnt_q == HALF_M1) begin
                    if (!rxs) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            // LSB arrives first, so shifting in at the MSB leaves bit 0 in
            // sh[0] after the eighth sample.
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    sh_d  = {rxs, sh_q[7:1]};
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            // Returning to IDLE at the stop-bit midpoint leaves half a bit of
            // slack to catch a start bit that follows with no idle gap.
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rxs) begin
                        char_d  = ws_map(sh_q);
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            // A line held low would otherwise look like an endless series of
            // zero frames; wait for it to go idle so one break gives one error.
            BREAK: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign char_out    = char_q;
    assign char_valid  = valid_q;
    assign frame_err   = err_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_char_rx.sv
// tb_uart_char_rx
// Directed scenarios for uart_char_rx at 16 clk per bit. Drivers push the
// expected {frame_err, char_out} into exp_q; a monitor pops and compares
// whenever the DUT strobes char_valid or frame_err.
module tb_uart_char_rx;

    logic       clk;
    logic       reset;
    logic       rxd;
    logic [7:0] char_out;
    logic       char_valid;
    logic       frame_err;
    logic       busy;
    logic [2:0] dbg_state;

    uart_char_rx #(
        .CLKS_PER_BIT (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rxd         (rxd),
        .char_out    (char_out),
        .char_valid  (char_valid),
        .frame_err   (frame_err),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int         total = 0;
    int         bad = 0;
    int         n_valid = 0;
    int         n_err = 0;
    int         last_valid_cyc = -1;
    logic [8:0] exp_q[$];
    logic [8:0] mon_e;
    logic [7:0] last_char;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (char_valid && frame_err) begin
                check("valid_err_overlap", 32'd1, 32'd0);
            end
            if (char_valid || frame_err) begin
                if (char_valid) begin
                    n_valid++;
                    last_valid_cyc = cyc;
                end
                if (frame_err) n_err++;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {23'd0, frame_err, char_out}, 32'h1ff);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("output", {23'd0, frame_err, char_out}, {23'd0, mon_e});
                end
            end
        end
    end

    // ---------------- drivers ----------------
    // Must be entered at a negedge; leaves the line idle high on return.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (16) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (16) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] raw, input logic [7:0] expc);
        exp_q.push_back({1'b0, expc});
        last_char = expc;
        send_frame(raw, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] s1_raw[9] = '{8'h42, 8'h65, 8'h67, 8'h69, 8'h6E, 8'h09, 8'h65, 8'h6E, 8'h64};
    logic [7:0] s1_exp[9] = '{8'h42, 8'h65, 8'h67, 8'h69, 8'h6E, 8'h20, 8'h65, 8'h6E, 8'h64};
    logic [7:0] s2_raw[5] = '{8'h0D, 8'h0A, 8'h00, 8'h9A, 8'h5A};
    logic [7:0] s2_exp[5] = '{8'h20, 8'h20, 8'h00, 8'h9A, 8'h5A};
    logic [7:0] rst_byte  = 8'h33;

    initial begin
        int t0;
        int v0;
        int e0;

        reset     = 1'b1;
        rxd       = 1'b1;
        last_char = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_char_out", {24'd0, char_out}, 32'h0);
        check("rst_char_valid", {31'd0, char_valid}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // single character with exact pulse timing
        t0 = cyc;
        v0 = n_valid;
        send_good(8'h62, 8'h62);
        repeat (20) @(negedge clk);
        check("single_count", n_valid - v0, 1);
        check("single_time", last_valid_cyc, t0 + 155);
        check("single_no_err", n_err, 0);

        // back-to-back "Begin\tend"
        v0 = n_valid;
        for (int i = 0; i < 9; i++) send_good(s1_raw[i], s1_exp[i]);
        repeat (20) @(negedge clk);
        check("stream_count", n_valid - v0, 9);

        // CR, LF, NUL, high byte, upper case
        v0 = n_valid;
        for (int i = 0; i < 5; i++) send_good(s2_raw[i], s2_exp[i]);
        repeat (20) @(negedge clk);
        check("map_count", n_valid - v0, 5);
        check("map_queue", exp_q.size(), 0);

        // start glitch
        t0 = cyc;
        v0 = n_valid;
        e0 = n_err;
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        @(negedge clk);
        check("glitch_busy_hi", {31'd0, busy}, 32'd1);
        repeat (6) @(negedge clk);
        check("glitch_busy_lo_at", cyc - t0, 11);
        check("glitch_busy_lo", {31'd0, busy}, 32'd0);
        repeat (200) @(negedge clk);
        check("glitch_no_char", n_valid - v0, 0);
        check("glitch_no_err", n_err - e0, 0);

        // framing error then a good frame
        v0 = n_valid;
        e0 = n_err;
        exp_q.push_back({1'b1, last_char});
        send_frame(8'h41, 1'b0);
        repeat (5) @(negedge clk);
        check("ferr_busy", {31'd0, busy}, 32'd0);
        check("ferr_err_count", n_err - e0, 1);
        check("ferr_no_char", n_valid - v0, 0);
        send_good(8'h42, 8'h42);
        repeat (20) @(negedge clk);
        check("ferr_recover", n_valid - v0, 1);

        // break: line held low
        v0 = n_valid;
        e0 = n_err;
        exp_q.push_back({1'b1, last_char});
        rxd = 1'b0;
        repeat (400) @(negedge clk);
        check("break_busy", {31'd0, busy}, 32'd1);
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        check("break_busy_lo", {31'd0, busy}, 32'd0);
        check("break_err_count", n_err - e0, 1);
        check("break_no_char", n_valid - v0, 0);

        // reset during data bit 4
        rxd = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = rst_byte[i];
            repeat (16) @(negedge clk);
        end
        rxd = rst_byte[4];
        repeat (8) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_char_out", {24'd0, char_out}, 32'h0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_valid", {31'd0, char_valid}, 32'd0);
        check("midrst_err", {31'd0, frame_err}, 32'd0);
        @(negedge clk);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        v0 = n_valid;
        send_good(8'h65, 8'h65);
        repeat (20) @(negedge clk);
        check("midrst_recover", n_valid - v0, 1);
        check("midrst_char", {24'd0, char_out}, 32'h65);

        check("final_queue", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
